answer_countdown: RTL and testbench

//  Downstream of the responder select stage: consumes Timer_Start/Player_Number, runs the answer-time countdown.

---
 rtl/answer_countdown_pkg.sv | 53 +++++
 rtl/answer_countdown_if.sv | 13 +
 rtl/answer_countdown_seg_scan.sv | 67 ++++++
 rtl/answer_countdown.sv | 136 +++++++++++++
 tb/tb_answer_countdown.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/answer_countdown_pkg.sv
// Shared types and helpers for the answer-time countdown: FSM state encoding,
// 4-bit glyph codes for the 7-segment display, and BCD arithmetic.
package answer_countdown_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COUNT   = 2'd1,
    ST_EXPIRED = 2'd2
  } state_t;

  // Glyph codes 0..9 are the decimal digits themselves.
  localparam logic [3:0] GLYPH_P     = 4'd10;
  localparam logic [3:0] GLYPH_DASH  = 4'd11;
  localparam logic [3:0] GLYPH_BLANK = 4'd12;

  // Counter width for a divisor; never below one bit so a divisor of 1 still builds.
  function automatic int cnt_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Packed BCD {tens,ones} of a 0..99 value.
  function automatic logic [7:0] to_bcd(input int unsigned v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  // One-second BCD decrement; the ones digit borrows from the tens digit.
  function automatic logic [7:0] bcd_dec(input logic [7:0] v);
    if (v[3:0] == 4'd0) return {v[7:4] - 4'd1, 4'd9};
    return {v[7:4], v[3:0] - 4'd1};
  endfunction

  // Segment pattern {dp,g,f,e,d,c,b,a}, active-low, dp always off.
  function automatic logic [7:0] glyph_seg(input logic [3:0] code);
    logic [7:0] seg;
    case (code)
      4'd0:    seg = 8'hC0;
      4'd1:    seg = 8'hF9;
      4'd2:    seg = 8'hA4;
      4'd3:    seg = 8'hB0;
      4'd4:    seg = 8'h99;
      4'd5:    seg = 8'h92;
      4'd6:    seg = 8'h82;
      4'd7:    seg = 8'hF8;
      4'd8:    seg = 8'h80;
      4'd9:    seg = 8'h90;
      4'd10:   seg = 8'h8C;
      4'd11:   seg = 8'hBF;
      default: seg = 8'hFF;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/answer_countdown_if.sv
// Link from the responder select stage into the countdown.
// Protocol: there is no valid/ready pair. Start is a level that enables the
// round (low aborts to idle). A player buzz-in is the rising edge of
// Timer_Start while Start is high; Player_Number must be stable on that edge
// and is captured only then.
interface answer_countdown_if;
  logic       Start;
  logic       Timer_Start;
  logic [3:0] Player_Number;

  modport master (output Start, output Timer_Start, output Player_Number);
  modport slave  (input  Start, input  Timer_Start, input  Player_Number);
endinterface

// File: rtl/answer_countdown_seg_scan.sv
// Four-digit multiplexed 7-segment driver. A free-running prescaler steps the
// digit index; Seg and Sel are registered from the same index on the same edge
// so the selected digit and its pattern always change together.
module answer_countdown_seg_scan
  import answer_countdown_pkg::*;
#(
  parameter int unsigned SCAN_DIV = 12_500
) (
  input  logic       CLK,
  input  logic       Rstn,
  input  logic [3:0] i_code0,
  input  logic [3:0] i_code1,
  input  logic [3:0] i_code2,
  input  logic [3:0] i_code3,
  output logic [7:0] o_seg,
  output logic [3:0] o_sel
);

  localparam int SW = cnt_w(SCAN_DIV);
  localparam logic [SW-1:0] SCAN_MAX = SW'(SCAN_DIV - 1);

  logic [SW-1:0] r_scan_cnt;
  logic [1:0]    r_digit;
  logic [3:0]    w_code;
  logic [7:0]    r_seg;
  logic [3:0]    r_sel;

  // Scan prescaler and digit index, advancing 0->1->2->3->0.
  always_ff @(posedge CLK or negedge Rstn) begin
    if (!Rstn) begin
      r_scan_cnt <= '0;
      r_digit    <= 2'd0;
    end else if (r_scan_cnt == SCAN_MAX) begin
      r_scan_cnt <= '0;
      r_digit    <= r_digit + 2'd1;
    end else begin
      r_scan_cnt <= r_scan_cnt + 1'b1;
    end
  end

  // Pick the glyph code of the digit currently being scanned.
  always_comb begin
    w_code = i_code0;
    case (r_digit)
      2'd0: w_code = i_code0;
      2'd1: w_code = i_code1;
      2'd2: w_code = i_code2;
      2'd3: w_code = i_code3;
      default: w_code = i_code0;
    endcase
  end

  // Register select and segments together; all dark in reset.
  always_ff @(posedge CLK or negedge Rstn) begin
    if (!Rstn) begin
      r_seg <= 8'hFF;
      r_sel <= 4'hF;
    end else begin
      r_seg <= glyph_seg(w_code);
      r_sel <= ~(4'b0001 << r_digit);
    end
  end

  assign o_seg = r_seg;
  assign o_sel = r_sel;

endmodule

// File: rtl/answer_countdown.sv
// Answer-time countdown following the responder select stage. A buzz-in starts
// a seconds countdown in BCD; expiry raises Timeout and a timed buzzer pulse;
// releasing Start returns to idle from anywhere.
module answer_countdown
  import answer_countdown_pkg::*;
#(
  parameter int unsigned CLK_HZ      = 50_000_000,
  parameter int unsigned ANSWER_SEC  = 30,
  parameter int unsigned SCAN_DIV    = 12_500,
  parameter int unsigned BEEP_CYCLES = 25_000_000
) (
  input  logic                CLK,
  input  logic                Rstn,
  answer_countdown_if.slave   bus,
  output logic [7:0]          Time_Left,
  output logic                Timeout,
  output logic                Buzzer_Timeout,
  output logic [7:0]          Seg,
  output logic [3:0]          Sel,
  output state_t              o_dbg_state
);

  localparam int SECW  = cnt_w(CLK_HZ);
  localparam int BEEPW = cnt_w(BEEP_CYCLES);
  localparam logic [SECW-1:0]  SEC_MAX     = SECW'(CLK_HZ - 1);
  localparam logic [BEEPW-1:0] BEEP_MAX    = BEEPW'(BEEP_CYCLES - 1);
  localparam logic [7:0]       TIME_RELOAD = to_bcd(ANSWER_SEC);

  state_t           r_state;
  state_t           w_next_state;
  logic             r_ts_d;
  logic [3:0]       r_player;
  logic [SECW-1:0]  r_sec_cnt;
  logic [7:0]       r_time;
  logic [BEEPW-1:0] r_beep_cnt;
  logic             r_buzz;
  logic             w_trig;
  logic             w_tick;
  logic [3:0]       w_code0, w_code1, w_code2, w_code3;

  // A reset-cleared edge register makes Timer_Start already high at reset release count as a buzz-in.
  assign w_trig = bus.Timer_Start & ~r_ts_d & bus.Start;
  assign w_tick = (r_state == ST_COUNT) && (r_sec_cnt == SEC_MAX);

  // State register.
  always_ff @(posedge CLK or negedge Rstn) begin
    if (!Rstn) r_state <= ST_IDLE;
    else       r_state <= w_next_state;
  end

  // Next-state logic; Start low has priority over tick and trigger.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:    if (w_trig) w_next_state = ST_COUNT;
      ST_COUNT: begin
        if (!bus.Start)                        w_next_state = ST_IDLE;
        else if (w_tick && r_time == 8'h01)    w_next_state = ST_EXPIRED;
      end
      ST_EXPIRED: if (!bus.Start) w_next_state = ST_IDLE;
      default:    w_next_state = ST_IDLE;
    endcase
  end

  // Outputs and display glyph codes decoded from state and datapath.
  always_comb begin
    Timeout = (r_state == ST_EXPIRED);
    w_code3 = (r_state == ST_IDLE) ? GLYPH_DASH : GLYPH_P;
    if (r_state == ST_IDLE || r_player == 4'd0 || r_player > 4'd4) w_code2 = GLYPH_DASH;
    else                                                           w_code2 = r_player;
    w_code1 = (r_time[7:4] == 4'd0) ? GLYPH_BLANK : r_time[7:4];
    w_code0 = r_time[3:0];
  end

  // Timer_Start history and player latch, captured only on a buzz-in from idle.
  always_ff @(posedge CLK or negedge Rstn) begin
    if (!Rstn) begin
      r_ts_d   <= 1'b0;
      r_player <= 4'd0;
    end else begin
      r_ts_d <= bus.Timer_Start;
      if (r_state == ST_IDLE && w_trig) r_player <= bus.Player_Number;
    end
  end

  // One-second prescaler, running only while counting and cleared otherwise.
  always_ff @(posedge CLK or negedge Rstn) begin
    if (!Rstn)                                    r_sec_cnt <= '0;
    else if (r_state == ST_COUNT && bus.Start)    r_sec_cnt <= (r_sec_cnt == SEC_MAX) ? '0 : r_sec_cnt + 1'b1;
    else                                          r_sec_cnt <= '0;
  end

  // BCD seconds: reload when idle or aborting, decrement on each tick.
  always_ff @(posedge CLK or negedge Rstn) begin
    if (!Rstn)                                    r_time <= TIME_RELOAD;
    else if (!bus.Start || r_state == ST_IDLE)    r_time <= TIME_RELOAD;
    else if (w_tick)                              r_time <= bcd_dec(r_time);
  end

  // Buzzer pulse of BEEP_CYCLES cycles starting on entry into expiry.
  always_ff @(posedge CLK or negedge Rstn) begin
    if (!Rstn) begin
      r_buzz     <= 1'b0;
      r_beep_cnt <= '0;
    end else if (r_state != ST_EXPIRED && w_next_state == ST_EXPIRED) begin
      r_buzz     <= 1'b1;
      r_beep_cnt <= '0;
    end else if (w_next_state != ST_EXPIRED) begin
      r_buzz     <= 1'b0;
      r_beep_cnt <= '0;
    end else if (r_buzz) begin
      if (r_beep_cnt == BEEP_MAX) begin
        r_buzz     <= 1'b0;
        r_beep_cnt <= '0;
      end else begin
        r_beep_cnt <= r_beep_cnt + 1'b1;
      end
    end
  end

  assign Time_Left      = r_time;
  assign Buzzer_Timeout = r_buzz;
  assign o_dbg_state    = r_state;

  answer_countdown_seg_scan #(.SCAN_DIV(SCAN_DIV)) u_scan (
    .CLK     (CLK),
    .Rstn    (Rstn),
    .i_code0 (w_code0),
    .i_code1 (w_code1),
    .i_code2 (w_code2),
    .i_code3 (w_code3),
    .o_seg   (Seg),
    .o_sel   (Sel)
  );

endmodule

// File: tb/tb_answer_countdown.sv
// Bench for answer_countdown with small timing parameters. Expected values come
// from a seconds-elapsed model: remaining = ANSWER - elapsed/HZ, expiry at
// ANSWER*HZ cycles, buzzer for BEEP cycles after that.
module tb_answer_countdown;
  import answer_countdown_pkg::*;

  localparam int HZ   = 20;
  localparam int ANS  = 3;
  localparam int SDIV = 2;
  localparam int BEEP = 5;

  logic       CLK;
  logic       Rstn;
  logic [7:0] Time_Left;
  logic       Timeout;
  logic       Buzzer_Timeout;
  logic [7:0] Seg;
  logic [3:0] Sel;
  state_t     dbg_state;

  int total = 0;
  int bad   = 0;

  answer_countdown_if bus ();

  answer_countdown #(.CLK_HZ(HZ), .ANSWER_SEC(ANS), .SCAN_DIV(SDIV), .BEEP_CYCLES(BEEP)) dut (
    .CLK            (CLK),
    .Rstn           (Rstn),
    .bus            (bus),
    .Time_Left      (Time_Left),
    .Timeout        (Timeout),
    .Buzzer_Timeout (Buzzer_Timeout),
    .Seg            (Seg),
    .Sel            (Sel),
    .o_dbg_state    (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // ---------------- reference model ----------------
  function automatic int exp_sec(input int e);
    if (e >= ANS * HZ) return 0;
    return ANS - e / HZ;
  endfunction

  function automatic logic [7:0] exp_bcd(input int s);
    logic [7:0] r;
    r = 8'((s / 10) * 16 + (s % 10));
    return r;
  endfunction

  // code: 0..9 digits, 10 = P, 11 = dash, 12 = blank
  function automatic logic [7:0] exp_glyph(input int code);
    logic [6:0] p;
    case (code)
      0: p = 7'h3F; 1: p = 7'h06; 2: p = 7'h5B; 3: p = 7'h4F; 4: p = 7'h66;
      5: p = 7'h6D; 6: p = 7'h7D; 7: p = 7'h07; 8: p = 7'h7F; 9: p = 7'h6F;
      10: p = 7'h73; 11: p = 7'h40; default: p = 7'h00;
    endcase
    return {1'b1, ~p};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic start_round(input int pl);
    bus.Start = 1'b1;
    bus.Timer_Start = 1'b0;
    repeat ($urandom_range(1, 4)) @(negedge CLK);
    bus.Player_Number = 4'(pl);
    bus.Timer_Start = 1'b1;
  endtask

  task automatic end_round();
    bus.Start = 1'b0;
    bus.Timer_Start = 1'b0;
    repeat (2) @(negedge CLK);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [3:0] sel_seq [4];
    logic [7:0] es;
    sel_seq = '{4'hE, 4'hD, 4'hB, 4'h7};
    Rstn = 1'b0;
    bus.Start = 1'b0; bus.Timer_Start = 1'b0; bus.Player_Number = 4'd0;
    repeat (2) @(negedge CLK);
    total++; if (Time_Left !== 8'h03) begin bad++; $display("FAIL reset_time got=%h exp=03", Time_Left); end
    total++; if (Timeout !== 1'b0) begin bad++; $display("FAIL reset_timeout got=%b exp=0", Timeout); end
    total++; if (Buzzer_Timeout !== 1'b0) begin bad++; $display("FAIL reset_buzz got=%b exp=0", Buzzer_Timeout); end
    total++; if (Seg !== 8'hFF) begin bad++; $display("FAIL reset_seg got=%h exp=ff", Seg); end
    total++; if (Sel !== 4'hF) begin bad++; $display("FAIL reset_sel got=%h exp=f", Sel); end
    total++; if (dbg_state !== ST_IDLE) begin bad++; $display("FAIL reset_state got=%0d exp=%0d", dbg_state, ST_IDLE); end
    Rstn = 1'b1;
    for (int n = 1; n <= 12; n++) begin
      @(negedge CLK);
      total++;
      if (Sel !== sel_seq[((n - 1) / 2) % 4]) begin
        bad++; $display("FAIL scan_sel n=%0d got=%h exp=%h", n, Sel, sel_seq[((n - 1) / 2) % 4]);
      end
      case (sel_seq[((n - 1) / 2) % 4])
        4'hE:    es = exp_glyph(ANS % 10);
        4'hD:    es = exp_glyph(12);
        default: es = exp_glyph(11);
      endcase
      total++;
      if (Seg !== es) begin bad++; $display("FAIL idle_seg n=%0d got=%h exp=%h", n, Seg, es); end
    end
  endtask

  task automatic test_countdown();
    int pl, e, prev_s, s;
    logic prev_active;
    logic [7:0] es;
    pl = $urandom_range(1, 3);
    start_round(pl);
    prev_s = ANS; prev_active = 1'b0;
    for (int m = 1; m <= 75; m++) begin
      @(negedge CLK);
      e = m - 1;
      s = exp_sec(e);
      total++; if (Time_Left !== exp_bcd(s)) begin bad++; $display("FAIL count_time e=%0d got=%h exp=%h", e, Time_Left, exp_bcd(s)); end
      total++; if (Timeout !== (e >= ANS * HZ)) begin bad++; $display("FAIL count_timeout e=%0d got=%b", e, Timeout); end
      total++; if (Buzzer_Timeout !== (e >= ANS * HZ && e < ANS * HZ + BEEP)) begin bad++; $display("FAIL count_buzz e=%0d got=%b", e, Buzzer_Timeout); end
      total++;
      if (!(Sel inside {4'hE, 4'hD, 4'hB, 4'h7})) begin
        bad++; $display("FAIL count_sel e=%0d got=%h", e, Sel);
      end else begin
        case (Sel)
          4'h7:    es = exp_glyph(prev_active ? 10 : 11);
          4'hB:    es = exp_glyph(prev_active ? pl : 11);
          4'hD:    es = exp_glyph((prev_s / 10 == 0) ? 12 : prev_s / 10);
          default: es = exp_glyph(prev_s % 10);
        endcase
        total++;
        if (Seg !== es) begin bad++; $display("FAIL count_seg e=%0d sel=%h got=%h exp=%h", e, Sel, Seg, es); end
      end
      prev_s = s; prev_active = 1'b1;
      // Extra buzz-ins with another player during COUNT and during EXPIRED.
      if (m == 10 || m == 66) bus.Timer_Start = 1'b0;
      if (m == 12 || m == 68) begin bus.Player_Number = 4'd4; bus.Timer_Start = 1'b1; end
    end
    bus.Start = 1'b0;
    @(negedge CLK);
    total++; if (dbg_state !== ST_IDLE) begin bad++; $display("FAIL release_state got=%0d", dbg_state); end
    total++; if (Time_Left !== 8'h03) begin bad++; $display("FAIL release_time got=%h exp=03", Time_Left); end
    total++; if (Timeout !== 1'b0) begin bad++; $display("FAIL release_timeout got=%b exp=0", Timeout); end
    end_round();
  endtask

  task automatic test_abort();
    int seen;
    start_round($urandom_range(1, 4));
    repeat (31) @(negedge CLK);
    bus.Start = 1'b0;
    @(negedge CLK);
    total++; if (dbg_state !== ST_IDLE) begin bad++; $display("FAIL abort_state got=%0d", dbg_state); end
    total++; if (Time_Left !== 8'h03) begin bad++; $display("FAIL abort_time got=%h exp=03", Time_Left); end
    total++; if (Timeout !== 1'b0) begin bad++; $display("FAIL abort_timeout got=%b exp=0", Timeout); end
    seen = 0;
    for (int n = 0; n < 10; n++) begin
      @(negedge CLK);
      if (Sel == 4'h7 || Sel == 4'hB) begin
        seen++; total++;
        if (Seg !== exp_glyph(11)) begin bad++; $display("FAIL abort_dash sel=%h got=%h exp=%h", Sel, Seg, exp_glyph(11)); end
      end
    end
    total++; if (seen == 0) begin bad++; $display("FAIL abort_scan got=0 exp>0 digit3/2 scans"); end
    end_round();
  endtask

  task automatic test_tick_abort();
    start_round(1);
    for (int m = 1; m <= 40; m++) begin
      @(negedge CLK);
      total++;
      if (Time_Left !== exp_bcd(exp_sec(m - 1))) begin bad++; $display("FAIL tick_pre e=%0d got=%h exp=%h", m - 1, Time_Left, exp_bcd(exp_sec(m - 1))); end
    end
    bus.Start = 1'b0;
    for (int n = 0; n < 4; n++) begin
      @(negedge CLK);
      total++; if (Time_Left !== 8'h03) begin bad++; $display("FAIL tick_abort n=%0d got=%h exp=03", n, Time_Left); end
    end
    total++; if (dbg_state !== ST_IDLE) begin bad++; $display("FAIL tick_abort_state got=%0d", dbg_state); end
    end_round();
  endtask

  task automatic test_invalid_player();
    int v, pl, seen;
    v = $urandom_range(4, 15);
    pl = (v == 4) ? 0 : v;
    start_round(pl);
    seen = 0;
    for (int m = 1; m <= 12; m++) begin
      @(negedge CLK);
      total++; if (dbg_state !== ST_COUNT) begin bad++; $display("FAIL badpl_state m=%0d got=%0d", m, dbg_state); end
      if (m >= 2 && Sel == 4'hB) begin
        seen++; total++;
        if (Seg !== exp_glyph(11)) begin bad++; $display("FAIL badpl_dash pl=%0d got=%h exp=%h", pl, Seg, exp_glyph(11)); end
      end
    end
    total++; if (seen == 0) begin bad++; $display("FAIL badpl_scan got=0 exp>0 digit2 scans"); end
    end_round();
  endtask

  task automatic test_expired_reset();
    start_round(3);
    repeat (63) @(negedge CLK);
    total++; if (Buzzer_Timeout !== 1'b1) begin bad++; $display("FAIL exp_buzz got=%b exp=1", Buzzer_Timeout); end
    total++; if (Timeout !== 1'b1) begin bad++; $display("FAIL exp_timeout got=%b exp=1", Timeout); end
    #2 Rstn = 1'b0;
    #1;
    total++; if (Buzzer_Timeout !== 1'b0) begin bad++; $display("FAIL arst_buzz got=%b exp=0", Buzzer_Timeout); end
    total++; if (Timeout !== 1'b0) begin bad++; $display("FAIL arst_timeout got=%b exp=0", Timeout); end
    total++; if (Time_Left !== 8'h03) begin bad++; $display("FAIL arst_time got=%h exp=03", Time_Left); end
    total++; if (Sel !== 4'hF) begin bad++; $display("FAIL arst_sel got=%h exp=f", Sel); end
    // Timer_Start stays high through reset release: that counts as a buzz-in.
    @(negedge CLK);
    Rstn = 1'b1;
    for (int m = 1; m <= 21; m++) begin
      @(negedge CLK);
      total++; if (dbg_state !== ST_COUNT) begin bad++; $display("FAIL rel_state m=%0d got=%0d", m, dbg_state); end
      total++; if (Time_Left !== exp_bcd(exp_sec(m - 1))) begin bad++; $display("FAIL rel_time e=%0d got=%h exp=%h", m - 1, Time_Left, exp_bcd(exp_sec(m - 1))); end
    end
    end_round();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_countdown();
    test_abort();
    test_tick_abort();
    test_invalid_player();
    test_countdown();
    test_expired_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Bound on the whole run.
  initial begin
    #200000;
    bad++;
    $display("FAIL watchdog got=timeout exp=finish");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
